// File: rtl/elevator_sched_if.sv
// ---------------------------------------------------------------------------
// elevator_sched_if
//   Request / status bundle of the four-floor elevator scheduler.
//   master : drives the call-button pulses and the step enable, sees status.
//   slave  : the scheduler itself.
//   Signals:
//     tick       step enable (one pulse per scheduler step)
//     car_req    car-button pulses, bit f = floor f (1..4)
//     up_req     hall up-call pulses, floors 1..3
//     dn_req     hall down-call pulses, floors 2..4
//     car_pend   latched car calls
//     up_pend    latched hall up calls
//     dn_pend    latched hall down calls
//     floor      current floor 1..4
//     dir        00 idle, 01 up, 10 down
//     door_open  high while the door is open
//     state      00 IDLE, 01 MOVE, 10 DOOR, 11 CLOSE
// ---------------------------------------------------------------------------
interface elevator_sched_if;
  logic       tick;
  logic [4:1] car_req;
  logic [3:1] up_req;
  logic [4:2] dn_req;
  logic [4:1] car_pend;
  logic [3:1] up_pend;
  logic [4:2] dn_pend;
  logic [2:0] floor;
  logic [1:0] dir;
  logic       door_open;
  logic [1:0] state;

  modport master (
    output tick, car_req, up_req, dn_req,
    input  car_pend, up_pend, dn_pend, floor, dir, door_open, state
  );

  modport slave (
    input  tick, car_req, up_req, dn_req,
    output car_pend, up_pend, dn_pend, floor, dir, door_open, state
  );
endinterface

// File: rtl/elevator_sched.sv
// ---------------------------------------------------------------------------
// elevator_sched
//   Collective-control scheduler for a single car serving floors 1..4.
//   Calls are latched as they arrive; the car keeps going in its direction
//   while calls remain beyond it, stops for car calls and same-direction hall
//   calls, and reverses only when nothing is left ahead.
//   Ports:
//     clk   system clock, rising edge
//     clr   asynchronous reset, active low
//     bus   elevator_sched_if.slave (requests in, pend/floor/dir/state out)
//   Parameters:
//     DOOR_TICKS    ticks the door stays open (1..15)
//     TRAVEL_TICKS  ticks to travel one floor (1..15)
// ---------------------------------------------------------------------------
module elevator_sched #(
  parameter int DOOR_TICKS   = 3,
  parameter int TRAVEL_TICKS = 2
) (
  input logic             clk,
  input logic             clr,
  elevator_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_MOVE = 2'b01, S_DOOR = 2'b10, S_CLOSE = 2'b11} state_e;
  typedef enum logic [1:0] {D_IDLE = 2'b00, D_UP = 2'b01, D_DN = 2'b10} dir_e;

  // Calls are held as full 4-floor vectors; up[4] and dn[1] are never set,
  // which keeps every floor comparison uniform.
  typedef struct packed {
    logic [4:1] car;
    logic [4:1] up;
    logic [4:1] dn;
  } calls_t;

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  dir_e       way;
  logic [2:0] floor_q, floor_d;
  logic       lastdir_q, lastdir_d;
  logic [3:0] travel_q, travel_d;
  logic [3:0] door_q, door_d;
  logic       door_open_q;
  calls_t     pend_q, req, svc;
  logic [4:1] any_call;

  function automatic logic [4:1] at_mask(input logic [2:0] f);
    logic [4:1] m;
    m = '0;
    for (int i = 1; i <= 4; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  function automatic logic has_beyond(input logic [4:1] calls, input logic [2:0] f, input dir_e d);
    logic [4:1] m;
    m = '0;
    for (int i = 1; i <= 4; i++)
      m[i] = ((d == D_UP) && (i > int'(f))) || ((d == D_DN) && (i < int'(f)));
    return |(calls & m);
  endfunction

  function automatic dir_e flip(input dir_e d);
    return (d == D_UP) ? D_DN : D_UP;
  endfunction

  // Calls answered by an open door at floor f travelling in d. With nothing
  // left ahead the car may leave either way, so both hall calls are taken.
  function automatic calls_t service(input logic [4:1] calls, input logic [2:0] f, input dir_e d);
    calls_t     s;
    logic       all_hall;
    logic [4:1] here;
    here     = at_mask(f);
    all_hall = (d == D_IDLE) || !has_beyond(calls, f, d);
    s.car    = here;
    s.up     = ((d == D_UP) || all_hall) ? here : '0;
    s.dn     = ((d == D_DN) || all_hall) ? here : '0;
    return s;
  endfunction

  assign req      = {bus.car_req, 1'b0, bus.up_req, bus.dn_req, 1'b0};
  assign any_call = pend_q.car | pend_q.up | pend_q.dn;
  // Preferred travel direction: current one, or the last one when parked.
  assign way      = (dir_q != D_IDLE) ? dir_q : (lastdir_q ? D_UP : D_DN);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    lastdir_d = lastdir_q;
    travel_d  = travel_q;
    door_d    = door_q;
    svc       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.tick) begin
          if (|(any_call & at_mask(floor_q))) begin
            state_d = S_DOOR;
            door_d  = 4'(DOOR_TICKS);
            svc     = service(any_call, floor_q, D_IDLE);
          end else if (has_beyond(any_call, floor_q, way)) begin
            state_d   = S_MOVE;
            dir_d     = way;
            lastdir_d = (way == D_UP);
            travel_d  = '0;
          end else if (has_beyond(any_call, floor_q, flip(way))) begin
            state_d   = S_MOVE;
            dir_d     = flip(way);
            lastdir_d = (flip(way) == D_UP);
            travel_d  = '0;
          end
        end
      end

      S_MOVE: begin
        if (bus.tick) begin
          if (travel_q == 4'(TRAVEL_TICKS - 1)) begin
            travel_d = '0;
            floor_d  = (dir_q == D_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
            // Stop decision is taken against the floor just reached.
            if (|(pend_q.car & at_mask(floor_d)) ||
                |(((dir_q == D_UP) ? pend_q.up : pend_q.dn) & at_mask(floor_d)) ||
                !has_beyond(any_call, floor_d, dir_q)) begin
              state_d = S_DOOR;
              door_d  = 4'(DOOR_TICKS);
              svc     = service(any_call, floor_d, dir_q);
            end
          end else begin
            travel_d = travel_q + 4'd1;
          end
        end
      end

      S_DOOR: begin
        // Calls at this floor stay answered while the door is open; pressing
        // one again keeps the door open for a full period.
        svc = service(any_call, floor_q, dir_q);
        if (|(req & svc)) begin
          door_d = 4'(DOOR_TICKS);
        end else if (bus.tick) begin
          if (door_q <= 4'd1) begin
            state_d = S_CLOSE;
            door_d  = '0;
          end else begin
            door_d = door_q - 4'd1;
          end
        end
      end

      S_CLOSE: begin
        if (has_beyond(any_call, floor_q, way)) begin
          state_d   = S_MOVE;
          dir_d     = way;
          lastdir_d = (way == D_UP);
          travel_d  = '0;
        end else if (has_beyond(any_call, floor_q, flip(way))) begin
          state_d   = S_MOVE;
          dir_d     = flip(way);
          lastdir_d = (flip(way) == D_UP);
          travel_d  = '0;
        end else begin
          state_d = S_IDLE;
          dir_d   = D_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      dir_q       <= D_IDLE;
      floor_q     <= 3'd1;
      lastdir_q   <= 1'b1;
      travel_q    <= '0;
      door_q      <= '0;
      door_open_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      floor_q     <= floor_d;
      lastdir_q   <= lastdir_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      door_open_q <= (state_d == S_DOOR);
      // Clear wins over a same-cycle set on the same bit.
      pend_q      <= (pend_q | req) & ~svc;
    end
  end

  assign bus.car_pend  = pend_q.car;
  assign bus.up_pend   = pend_q.up[3:1];
  assign bus.dn_pend   = pend_q.dn[4:2];
  assign bus.floor     = floor_q;
  assign bus.dir       = dir_q;
  assign bus.door_open = door_open_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_elevator_sched.sv
// ---------------------------------------------------------------------------
// tb_elevator_sched
//   Self-checking bench for elevator_sched: reset state, a cycle-by-cycle
//   vector table for a single trip, hand-written multi-cycle scenarios, and
//   random traffic compared against an array-based reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elevator_sched;
  localparam int DOOR_TICKS   = 3;
  localparam int TRAVEL_TICKS = 2;

  logic clk = 1'b0;
  logic clr;

  elevator_sched_if bus ();

  elevator_sched #(.DOOR_TICKS(DOOR_TICKS), .TRAVEL_TICKS(TRAVEL_TICKS)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // States: 0 idle, 1 move, 2 door, 3 close. Directions: 0 none, 1 up, 2 down.
  int m_state, m_floor, m_dir, m_last, m_cnt, m_tmr;
  bit m_car[1:4], m_up[1:4], m_dn[1:4];
  bit m_sc[1:4], m_su[1:4], m_sd[1:4];

  function automatic bit m_any(input int f);
    return m_car[f] | m_up[f] | m_dn[f];
  endfunction

  function automatic bit m_beyond(input int f, input int d);
    for (int i = 1; i <= 4; i++)
      if (((d == 1 && i > f) || (d == 2 && i < f)) && m_any(i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_mark(input int f, input int d);
    bit all_hall;
    all_hall = (d == 0) || !m_beyond(f, d);
    m_sc[f] = 1'b1;
    if (d == 1 || all_hall) m_su[f] = 1'b1;
    if (d == 2 || all_hall) m_sd[f] = 1'b1;
  endtask

  task automatic m_enter_door(input int f, input int d);
    m_state = 2;
    m_dir   = d;
    m_tmr   = DOOR_TICKS;
    m_mark(f, d);
  endtask

  task automatic m_start(input int d);
    m_state = 1;
    m_dir   = d;
    m_last  = (d == 1) ? 1 : 0;
    m_cnt   = 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_floor = 1; m_dir = 0; m_last = 1; m_cnt = 0; m_tmr = 0;
    for (int i = 1; i <= 4; i++) begin
      m_car[i] = 0; m_up[i] = 0; m_dn[i] = 0;
    end
  endtask

  task automatic model_step(input bit t, input logic [4:1] c, input logic [3:1] u, input logic [4:2] d);
    bit rc[1:4], ru[1:4], rd[1:4];
    bit hit;
    int way, nf;
    for (int i = 1; i <= 4; i++) begin
      m_sc[i] = 0; m_su[i] = 0; m_sd[i] = 0;
      rc[i] = c[i];
      ru[i] = (i <= 3) ? u[i] : 1'b0;
      rd[i] = (i >= 2) ? d[i] : 1'b0;
    end
    way = (m_dir != 0) ? m_dir : (m_last == 1 ? 1 : 2);
    case (m_state)
      0: if (t) begin
        if (m_any(m_floor)) m_enter_door(m_floor, 0);
        else if (m_beyond(m_floor, way)) m_start(way);
        else if (m_beyond(m_floor, 3 - way)) m_start(3 - way);
      end
      1: if (t) begin
        if (m_cnt + 1 == TRAVEL_TICKS) begin
          m_cnt   = 0;
          nf      = (m_dir == 1) ? m_floor + 1 : m_floor - 1;
          m_floor = nf;
          if (m_car[nf] || (m_dir == 1 ? m_up[nf] : m_dn[nf]) || !m_beyond(nf, m_dir))
            m_enter_door(nf, m_dir);
        end else begin
          m_cnt++;
        end
      end
      2: begin
        m_mark(m_floor, m_dir);
        hit = 0;
        for (int i = 1; i <= 4; i++)
          hit |= (rc[i] & m_sc[i]) | (ru[i] & m_su[i]) | (rd[i] & m_sd[i]);
        if (hit) m_tmr = DOOR_TICKS;
        else if (t) begin
          if (m_tmr == 1) m_state = 3;
          m_tmr--;
        end
      end
      default: begin
        if (m_beyond(m_floor, way)) m_start(way);
        else if (m_beyond(m_floor, 3 - way)) m_start(3 - way);
        else begin
          m_state = 0;
          m_dir   = 0;
        end
      end
    endcase
    for (int i = 1; i <= 4; i++) begin
      m_car[i] = (m_car[i] | rc[i]) & ~m_sc[i];
      m_up[i]  = (m_up[i]  | ru[i]) & ~m_su[i];
      m_dn[i]  = (m_dn[i]  | rd[i]) & ~m_sd[i];
    end
  endtask

  function automatic logic [17:0] model_out();
    logic [4:1] c;
    logic [3:1] u;
    logic [4:2] d;
    for (int i = 1; i <= 4; i++) c[i] = m_car[i];
    for (int i = 1; i <= 3; i++) u[i] = m_up[i];
    for (int i = 2; i <= 4; i++) d[i] = m_dn[i];
    return {c, u, d, 3'(m_floor), 2'(m_dir), (m_state == 2), 2'(m_state)};
  endfunction

  function automatic logic [17:0] dut_out();
    return {bus.car_pend, bus.up_pend, bus.dn_pend, bus.floor, bus.dir, bus.door_open, bus.state};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit t, input logic [4:1] c, input logic [3:1] u, input logic [4:2] d);
    @(negedge clk);
    bus.tick = t; bus.car_req = c; bus.up_req = u; bus.dn_req = d;
    @(posedge clk);
    #1;
    bus.tick = 1'b0; bus.car_req = '0; bus.up_req = '0; bus.dn_req = '0;
    model_step(t, c, u, d);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    bus.tick = 1'b0; bus.car_req = '0; bus.up_req = '0; bus.dn_req = '0;
    @(negedge clk);
    clr = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         t;
    logic [4:1] c;
    logic [1:0] st;
    logic [2:0] fl;
    logic [1:0] dr;
    logic       door;
    logic [4:1] cp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:1] rc;
    logic [3:1] ru;
    logic [4:2] rd;

    clr = 1'b0;
    bus.tick = 1'b0; bus.car_req = '0; bus.up_req = '0; bus.dn_req = '0;
    model_reset();

    // Single trip to floor 3 after reset, one record per clock.
    tbl[0]  = '{1'b0, 4'b0100, 2'd0, 3'd1, 2'd0, 1'b0, 4'b0100};
    tbl[1]  = '{1'b1, 4'b0000, 2'd1, 3'd1, 2'd1, 1'b0, 4'b0100};
    tbl[2]  = '{1'b1, 4'b0000, 2'd1, 3'd1, 2'd1, 1'b0, 4'b0100};
    tbl[3]  = '{1'b1, 4'b0000, 2'd1, 3'd2, 2'd1, 1'b0, 4'b0100};
    tbl[4]  = '{1'b1, 4'b0000, 2'd1, 3'd2, 2'd1, 1'b0, 4'b0100};
    tbl[5]  = '{1'b1, 4'b0000, 2'd2, 3'd3, 2'd1, 1'b1, 4'b0000};
    tbl[6]  = '{1'b0, 4'b0000, 2'd2, 3'd3, 2'd1, 1'b1, 4'b0000};
    tbl[7]  = '{1'b1, 4'b0000, 2'd2, 3'd3, 2'd1, 1'b1, 4'b0000};
    tbl[8]  = '{1'b1, 4'b0000, 2'd2, 3'd3, 2'd1, 1'b1, 4'b0000};
    tbl[9]  = '{1'b1, 4'b0000, 2'd3, 3'd3, 2'd1, 1'b0, 4'b0000};
    tbl[10] = '{1'b1, 4'b0000, 2'd0, 3'd3, 2'd0, 1'b0, 4'b0000};
    tbl[11] = '{1'b1, 4'b0000, 2'd0, 3'd3, 2'd0, 1'b0, 4'b0000};

    // Reset state, and requests pulsed during reset are dropped.
    repeat (2) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'({4'b0, 3'b0, 3'b0, 3'd1, 2'd0, 1'b0, 2'd0}));
    bus.car_req = 4'b1111; bus.up_req = 3'b111; bus.dn_req = 3'b111;
    repeat (2) @(negedge clk);
    bus.car_req = '0; bus.up_req = '0; bus.dn_req = '0;
    clr = 1'b1;
    model_reset();
    step(1'b1, '0, '0, '0);
    check("reset_discard", 32'(dut_out()), 32'({4'b0, 3'b0, 3'b0, 3'd1, 2'd0, 1'b0, 2'd0}));

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].t, tbl[i].c, '0, '0);
      check($sformatf("vec%0d", i),
            32'({bus.state, bus.floor, bus.dir, bus.door_open, bus.car_pend}),
            32'({tbl[i].st, tbl[i].fl, tbl[i].dr, tbl[i].door, tbl[i].cp}));
    end

    // Up hall call on the way is served, then the trip continues.
    do_reset();
    step(1'b0, 4'b1000, '0, '0);
    step(1'b1, '0, '0, '0);
    step(1'b0, '0, 3'b010, '0);
    tick_n(2);
    check("up_stop_at2", 32'({bus.state, bus.floor, bus.up_pend, bus.car_pend}),
          32'({2'd2, 3'd2, 3'b000, 4'b1000}));
    tick_n(3);
    check("up_close_at2", 32'(bus.state), 32'(2'd3));
    step(1'b0, '0, '0, '0);
    check("up_resume", 32'({bus.state, bus.dir}), 32'({2'd1, 2'd1}));
    tick_n(4);
    check("up_arrive4", 32'({bus.state, bus.floor, bus.car_pend}), 32'({2'd2, 3'd4, 4'b0000}));

    // Down hall call passed going up, served after reversing.
    do_reset();
    step(1'b0, 4'b1000, '0, '0);
    step(1'b1, '0, '0, '0);
    step(1'b0, '0, '0, 3'b001);
    tick_n(2);
    check("dn_pass2", 32'({bus.state, bus.floor, bus.dn_pend}), 32'({2'd1, 3'd2, 3'b001}));
    tick_n(4);
    check("dn_door4", 32'({bus.state, bus.floor}), 32'({2'd2, 3'd4}));
    tick_n(3);
    step(1'b0, '0, '0, '0);
    check("dn_reverse", 32'({bus.state, bus.dir}), 32'({2'd1, 2'd2}));
    tick_n(2);
    check("dn_pass3", 32'({bus.state, bus.floor}), 32'({2'd1, 3'd3}));
    tick_n(2);
    check("dn_door2", 32'({bus.state, bus.floor, bus.dn_pend}), 32'({2'd2, 3'd2, 3'b000}));

    // Car button at the open floor reloads the door timer.
    do_reset();
    step(1'b0, 4'b0100, '0, '0);
    step(1'b1, '0, '0, '0);
    tick_n(4);
    check("reopen_door3", 32'({bus.state, bus.floor}), 32'({2'd2, 3'd3}));
    tick_n(1);
    step(1'b0, 4'b0100, '0, '0);
    check("reopen_pend", 32'({bus.state, bus.car_pend}), 32'({2'd2, 4'b0000}));
    tick_n(2);
    check("reopen_held", 32'({bus.door_open, bus.state}), 32'({1'b1, 2'd2}));
    tick_n(1);
    check("reopen_close", 32'({bus.door_open, bus.state}), 32'({1'b0, 2'd3}));

    // Asynchronous reset between floors 2 and 3.
    do_reset();
    step(1'b0, 4'b1000, 3'b100, 3'b001);
    step(1'b1, '0, '0, '0);
    tick_n(3);
    check("midmove_pre", 32'({bus.state, bus.floor}), 32'({2'd1, 3'd2}));
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("midmove_clr", 32'(dut_out()), 32'({4'b0, 3'b0, 3'b0, 3'd1, 2'd0, 1'b0, 2'd0}));
    @(negedge clk);
    clr = 1'b1;
    model_reset();

    // Parked at 2 with last direction down: serve 1 before 3.
    step(1'b0, 4'b0100, '0, '0);
    step(1'b1, '0, '0, '0);
    tick_n(4);
    tick_n(3);
    step(1'b0, '0, '0, '0);
    step(1'b0, 4'b0010, '0, '0);
    step(1'b1, '0, '0, '0);
    tick_n(2);
    tick_n(3);
    step(1'b0, '0, '0, '0);
    check("pref_idle2", 32'({bus.state, bus.floor, bus.dir}), 32'({2'd0, 3'd2, 2'd0}));
    step(1'b0, 4'b0001, 3'b100, '0);
    step(1'b1, '0, '0, '0);
    check("pref_down", 32'({bus.state, bus.dir}), 32'({2'd1, 2'd2}));
    tick_n(2);
    check("pref_door1", 32'({bus.state, bus.floor, bus.up_pend}), 32'({2'd2, 3'd1, 3'b100}));
    tick_n(3);
    step(1'b0, '0, '0, '0);
    check("pref_up", 32'({bus.state, bus.dir}), 32'({2'd1, 2'd1}));
    tick_n(4);
    check("pref_door3", 32'({bus.state, bus.floor, bus.up_pend}), 32'({2'd2, 3'd3, 3'b000}));

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 1; i <= 4; i++) rc[i] = ($urandom_range(0, 11) == 0);
      for (int i = 1; i <= 3; i++) ru[i] = ($urandom_range(0, 15) == 0);
      for (int i = 2; i <= 4; i++) rd[i] = ($urandom_range(0, 15) == 0);
      step(1'($urandom_range(0, 1)), rc, ru, rd);
      check($sformatf("rand%0d", n), 32'(dut_out()), 32'(model_out()));
      if (n_total - n_pass > 20) break;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
